// File: rtl/branch_trace_driver.sv
// rtl/branch_trace_driver.sv - branch record FIFO, predictor stepper and mispredict scorer; optional BRDRV_WINDOW_STATS_EN windowed miss stats
module branch_trace_driver #(
    parameter int ADDR_W    = 64,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4,
    parameter int CAP_DELAY = 2,
    parameter int CNT_W     = 32
`ifdef BRDRV_WINDOW_STATS_EN
    ,
    parameter int WINDOW    = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [ADDR_W-1:0] rec_addr,
    input  logic              rec_taken,
    input  logic              rec_last,
    output logic [ADDR_W-1:0] b_addr,
    output logic              b_taken,
    output logic              b_step,
    input  logic              prediction,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              miss_pulse,
    output logic              done
`ifdef BRDRV_WINDOW_STATS_EN
    ,
    output logic [CNT_W-1:0]  win_miss,
    output logic              win_valid
`endif
);

    localparam int REC_W  = ADDR_W + 2;
    localparam int WAIT_W = (CAP_DELAY > 1) ? $clog2(CAP_DELAY) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CAP_DELAY - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT1_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SCORE
    } state_t;

    // record storage and pointers
    logic [REC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              full, empty, push, pop;

    // issue/score state
    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic              b_taken_q, b_taken_d;
    logic              cur_last_q, cur_last_d;
    logic              b_step_q, b_step_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic              done_q, done_d;
    logic              score_fire, is_miss;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign rec_ready  = !full;
    assign push       = rec_valid && !full;
    // the pop is the IDLE->ISSUE transition; nothing is issued once done is set
    assign pop        = (state_q == S_IDLE) && !empty && !done_q;
    assign score_fire = (state_q == S_SCORE);
    assign is_miss    = (prediction != b_taken_q);

    assign b_addr     = b_addr_q;
    assign b_taken    = b_taken_q;
    assign b_step     = b_step_q;
    assign total_cnt  = total_q;
    assign miss_cnt   = miss_q;
    assign miss_pulse = miss_pulse_q;
    assign done       = done_q;

    // record payload write; storage needs no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rec_addr, rec_taken, rec_last};
        end
    end

    // pointer and occupancy update; a push while full never happens since ready is low
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT1_ONE;
            2'b01:   count_d = count_q - CNT1_ONE;
            default: count_d = count_q;
        endcase
    end

    // pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // issue/wait/score sequencing with saturating statistics
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        b_addr_d     = b_addr_q;
        b_taken_d    = b_taken_q;
        cur_last_d   = cur_last_q;
        b_step_d     = 1'b0;
        total_d      = total_q;
        miss_d       = miss_q;
        miss_pulse_d = 1'b0;
        done_d       = done_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {b_addr_d, b_taken_d, cur_last_d} = mem_q[rd_ptr_q];
                    b_step_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (CAP_DELAY == 1) begin
                    state_d = S_SCORE;
                end else begin
                    wait_d  = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = wait_q - WAIT_ONE;
                if (wait_q == WAIT_ONE) begin
                    state_d = S_SCORE;
                end
            end
            S_SCORE: begin
                if (total_q != '1) begin
                    total_d = total_q + CNT_ONE;
                end
                if (is_miss) begin
                    miss_pulse_d = 1'b1;
                    if (miss_q != '1) begin
                        miss_d = miss_q + CNT_ONE;
                    end
                end
                if (cur_last_q) begin
                    done_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            b_addr_q     <= '0;
            b_taken_q    <= 1'b0;
            cur_last_q   <= 1'b0;
            b_step_q     <= 1'b0;
            total_q      <= '0;
            miss_q       <= '0;
            miss_pulse_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            b_addr_q     <= b_addr_d;
            b_taken_q    <= b_taken_d;
            cur_last_q   <= cur_last_d;
            b_step_q     <= b_step_d;
            total_q      <= total_d;
            miss_q       <= miss_d;
            miss_pulse_q <= miss_pulse_d;
            done_q       <= done_d;
        end
    end

`ifdef BRDRV_WINDOW_STATS_EN
    localparam int WCNT_W = $clog2(WINDOW + 1);
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW - 1);
    localparam logic [WCNT_W-1:0] WIN_ONE  = WCNT_W'(1);

    logic [WCNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  win_acc_q, win_acc_d;
    logic [CNT_W-1:0]  win_miss_q, win_miss_d;
    logic              win_valid_q, win_valid_d;
    logic [CNT_W-1:0]  miss_inc;

    assign miss_inc  = is_miss ? CNT_ONE : '0;
    assign win_miss  = win_miss_q;
    assign win_valid = win_valid_q;

    // per-window miss tally; a full window publishes its count and restarts from zero
    always_comb begin
        win_cnt_d   = win_cnt_q;
        win_acc_d   = win_acc_q;
        win_miss_d  = win_miss_q;
        win_valid_d = 1'b0;
        if (score_fire) begin
            if (win_cnt_q == WIN_LAST) begin
                win_miss_d  = win_acc_q + miss_inc;
                win_valid_d = 1'b1;
                win_cnt_d   = '0;
                win_acc_d   = '0;
            end else begin
                win_cnt_d = win_cnt_q + WIN_ONE;
                win_acc_d = win_acc_q + miss_inc;
            end
        end
    end

    // window statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q   <= '0;
            win_acc_q   <= '0;
            win_miss_q  <= '0;
            win_valid_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            win_acc_q   <= win_acc_d;
            win_miss_q  <= win_miss_d;
            win_valid_q <= win_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_branch_trace_driver.sv
// tb/tb_branch_trace_driver.sv - randomized self-checking bench for branch_trace_driver with a transaction-level model
module tb_branch_trace_driver;

    localparam int ADDR_W    = 64;
    localparam int DEPTH     = 16;
    localparam int PTR_W     = 4;
    localparam int CAP_DELAY = 2;
    localparam int CNT_W     = 4;
    localparam int WINDOW    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rec_valid = 1'b0;
    logic              rec_ready;
    logic [ADDR_W-1:0] rec_addr = '0;
    logic              rec_taken = 1'b0;
    logic              rec_last = 1'b0;
    logic [ADDR_W-1:0] b_addr;
    logic              b_taken;
    logic              b_step;
    logic              prediction = 1'b0;
    logic [CNT_W-1:0]  total_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic              miss_pulse;
    logic              done;
`ifdef BRDRV_WINDOW_STATS_EN
    logic [CNT_W-1:0]  win_miss;
    logic              win_valid;
`endif

    always #5 clk = ~clk;

    branch_trace_driver #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .CAP_DELAY(CAP_DELAY), .CNT_W(CNT_W)
`ifdef BRDRV_WINDOW_STATS_EN
        , .WINDOW(WINDOW)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
        .rec_taken(rec_taken), .rec_last(rec_last),
        .b_addr(b_addr), .b_taken(b_taken), .b_step(b_step), .prediction(prediction),
        .total_cnt(total_cnt), .miss_cnt(miss_cnt), .miss_pulse(miss_pulse), .done(done)
`ifdef BRDRV_WINDOW_STATS_EN
        , .win_miss(win_miss), .win_valid(win_valid)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              taken;
        logic              last;
    } rec_t;

    // reference model: queue of accepted records, in-flight branch and its remaining cycles
    rec_t             fifo_m[$];
    rec_t             cur_m;
    int               busy_m;
    int               issued_m;
    int               old_size;
    logic [CNT_W-1:0] tot_m, miss_m;
    logic             pulse_m, done_m;
    int               win_cnt_m, win_acc_m, win_miss_m;
    logic             win_valid_m;

    int               pmode = 0;
    logic [7:0]       miss_mask = 8'h00;
    int               pulses_seen = 0;
    int               steps_seen = 0;
    int               win_seen = 0;
    time              first_step = 0;
    time              last_step = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                fifo_m.delete();
                cur_m = '0;
                busy_m = 0; issued_m = 0;
                tot_m = '0; miss_m = '0; pulse_m = 1'b0; done_m = 1'b0;
                win_cnt_m = 0; win_acc_m = 0; win_miss_m = 0; win_valid_m = 1'b0;
            end else begin
                old_size = fifo_m.size();
                pulse_m = 1'b0;
                win_valid_m = 1'b0;
                if (busy_m > 0) begin
                    busy_m--;
                    if (busy_m == 0) begin
                        if (tot_m != '1) tot_m++;
                        if (prediction != cur_m.taken) begin
                            pulse_m = 1'b1;
                            if (miss_m != '1) miss_m++;
                            win_acc_m++;
                        end
                        if (cur_m.last) done_m = 1'b1;
                        win_cnt_m++;
                        if (win_cnt_m == WINDOW) begin
                            win_miss_m = win_acc_m;
                            win_valid_m = 1'b1;
                            win_cnt_m = 0;
                            win_acc_m = 0;
                        end
                    end
                end else if (old_size > 0 && !done_m) begin
                    cur_m = fifo_m.pop_front();
                    busy_m = CAP_DELAY + 1;
                    issued_m++;
                end
                if (rec_valid && old_size < DEPTH) begin
                    fifo_m.push_back('{addr: rec_addr, taken: rec_taken, last: rec_last});
                end
            end
        end
    end

    // per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rec_ready", 64'(rec_ready), 64'(fifo_m.size() < DEPTH));
                check("b_step", 64'(b_step), 64'(busy_m == CAP_DELAY + 1));
                check("b_addr", b_addr, cur_m.addr);
                check("b_taken", 64'(b_taken), 64'(cur_m.taken));
                check("total_cnt", 64'(total_cnt), 64'(tot_m));
                check("miss_cnt", 64'(miss_cnt), 64'(miss_m));
                check("miss_pulse", 64'(miss_pulse), 64'(pulse_m));
                check("done", 64'(done), 64'(done_m));
`ifdef BRDRV_WINDOW_STATS_EN
                check("win_valid", 64'(win_valid), 64'(win_valid_m));
                check("win_miss", 64'(win_miss), 64'(win_miss_m));
                if (win_valid) win_seen++;
`endif
                if (miss_pulse) pulses_seen++;
                if (b_step) begin
                    if (steps_seen == 0) first_step = $time;
                    last_step = $time;
                    steps_seen++;
                end
            end
        end
    end

    // predictor stand-in
    initial begin
        forever begin
            @(negedge clk);
            case (pmode)
                0:       prediction = 1'b0;
                1:       prediction = b_taken;
                2:       prediction = 1'($urandom);
                default: prediction = b_taken ^ ((issued_m > 0 && issued_m <= 8) ? miss_mask[issued_m-1] : 1'b0);
            endcase
        end
    end

    task automatic do_reset();
        rec_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_b_step", 64'(b_step), 64'd0);
        check("rst_b_addr", b_addr, 64'd0);
        check("rst_total", 64'(total_cnt), 64'd0);
        check("rst_miss", 64'(miss_cnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(rec_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pulses_seen = 0; steps_seen = 0; win_seen = 0;
        @(negedge clk);
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic t, input logic l);
        logic acc;
        rec_valid = 1'b1; rec_addr = a; rec_taken = t; rec_last = l;
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            acc = rec_ready;
            @(negedge clk);
            if (acc) break;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        rec_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        check("done_reached", 64'(done), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // single record, predictor stuck at not-taken
        do_reset();
        pmode = 0;
        send(64'h40, 1'b1, 1'b1);
        wait_done();
        check("t1_total", 64'(total_cnt), 64'd1);
        check("t1_miss", 64'(miss_cnt), 64'd1);
        check("t1_pulses", 64'(pulses_seen), 64'd1);
        check("t1_steps", 64'(steps_seen), 64'd1);
        check("t1_b_addr", b_addr, 64'h40);
        check("t1_b_taken", 64'(b_taken), 64'd1);

        // done blocks issue, so the FIFO fills and the 17th record is held
        for (int i = 0; i < DEPTH; i++) send({$urandom, $urandom}, 1'($urandom), 1'b0);
        check("fill_ready_low", 64'(rec_ready), 64'd0);
        rec_valid = 1'b1; rec_addr = 64'hdead;
        repeat (5) @(negedge clk);
        check("fill_held", 64'(rec_ready), 64'd0);
        rec_valid = 1'b0;
        check("fill_no_issue", 64'(steps_seen), 64'd1);

        // ten perfectly predicted branches, back to back
        do_reset();
        pmode = 1;
        for (int i = 0; i < 10; i++) send({$urandom, $urandom}, 1'($urandom), i == 9);
        wait_done();
        check("t2_total", 64'(total_cnt), 64'd10);
        check("t2_miss", 64'(miss_cnt), 64'd0);
        check("t2_pulses", 64'(pulses_seen), 64'd0);
        check("t2_steps", 64'(steps_seen), 64'd10);
        check("t2_spacing", 64'(last_step - first_step), 64'(9 * (CAP_DELAY + 2) * 10));

        // reset while the third branch is waiting on its prediction
        do_reset();
        pmode = 2;
        for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 1'($urandom), i == 4);
        for (int i = 0; i < 200 && !(issued_m == 3 && busy_m == CAP_DELAY); i++) @(negedge clk);
        check("t3_reached_wait", 64'(issued_m == 3 && busy_m == CAP_DELAY), 64'd1);
        do_reset();
        send(64'h1234, 1'b0, 1'b1);
        wait_done();
        check("t3_total", 64'(total_cnt), 64'd1);

        // twenty mispredicts saturate 4-bit counters
        do_reset();
        pmode = 0;
        for (int i = 0; i < 20; i++) send({$urandom, $urandom}, 1'b1, i == 19);
        wait_done();
        check("t4_total_sat", 64'(total_cnt), 64'd15);
        check("t4_miss_sat", 64'(miss_cnt), 64'd15);
        check("t4_pulses", 64'(pulses_seen), 64'd20);

        // random traces with random gaps and random predictions
        for (int p = 0; p < 4; p++) begin
            int n;
            do_reset();
            pmode = $urandom_range(0, 2);
            n = $urandom_range(3, 14);
            for (int i = 0; i < n; i++) begin
                send({$urandom, $urandom}, 1'($urandom), i == n - 1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_done();
            check("rand_total", 64'(total_cnt), 64'(n));
        end

`ifdef BRDRV_WINDOW_STATS_EN
        // misses on branches 2, 3 and 7 over two windows of four
        do_reset();
        miss_mask = 8'b0100_0110;
        pmode = 3;
        for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 1'($urandom), i == 7);
        wait_done();
        check("win_pulses", 64'(win_seen), 64'd2);
        check("win_last", 64'(win_miss), 64'd1);
        check("win_total_miss", 64'(miss_cnt), 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
